// File: rtl/cp0_exception_controller.sv
// rtl/cp0_exception_controller.sv - CP0 exception/interrupt controller beside the M stage.
// Holds SR/Cause/EPC, decides exception entry, services mfc0/mtc0/eret.
module cp0_exception_controller #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h5335_2E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic        take_exc,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out,
  output logic        exl
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts look at the live lines, not the IP copy, so a take is same-cycle.
  assign int_req = ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req = exc_valid & ~exl_q;
  assign take_exc = ~reset & (int_req | exc_req);

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = epc_q;
  assign exl        = exl_q;

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ip_d      = hw_int;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    if (take_exc) begin
      exl_d     = 1'b1;
      bd_d      = in_delay_slot;
      exccode_d = int_req ? 5'd0 : exc_code;
      epc_d     = in_delay_slot ? (pc - 32'd4) : pc;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (cp0_we) begin
      if (cp0_addr == REG_SR) begin
        im_d  = cp0_wdata[15:10];
        exl_d = cp0_wdata[1];
        ie_d  = cp0_wdata[0];
      end else if (cp0_addr == REG_EPC) begin
        epc_d = cp0_wdata;
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_word;
      REG_CAUSE: cp0_rdata = cause_word;
      REG_EPC:   cp0_rdata = epc_q;
      REG_PRID:  cp0_rdata = PRID_VALUE;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception_controller.sv
// tb/tb_cp0_exception_controller.sv - directed and randomized checks of the CP0 controller.
// Reference model holds SR/Cause/EPC as whole 32-bit words updated by the architectural rules.
module tb_cp0_exception_controller;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h5335_2E00;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        take_exc;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exception_controller dut (
    .clk(clk), .reset(reset), .pc(pc), .in_delay_slot(in_delay_slot),
    .exc_valid(exc_valid), .exc_code(exc_code), .hw_int(hw_int),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .eret(eret),
    .cp0_rdata(cp0_rdata), .take_exc(take_exc), .handler_pc(handler_pc),
    .epc_out(epc_out), .exl(exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_irq();
    return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic model_take();
    return !reset && (model_irq() || (exc_valid && !m_sr[1]));
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle();
    reset = 0; pc = 32'd0; in_delay_slot = 0; exc_valid = 0; exc_code = 5'd0;
    hw_int = 6'd0; cp0_we = 0; cp0_addr = 5'd0; cp0_wdata = 32'd0; eret = 0;
  endtask

  // Advance one clock, updating the reference model from the inputs held before the edge.
  task automatic tick();
    logic [31:0] n_sr, n_cause, n_epc;
    logic tk, irq;
    irq = model_irq();
    tk = model_take();
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    if (reset) begin
      n_sr = 0; n_cause = 0; n_epc = 0;
    end else begin
      n_cause[15:10] = hw_int;
      if (tk) begin
        n_sr[1] = 1'b1;
        n_cause[31] = in_delay_slot;
        n_cause[6:2] = irq ? 5'd0 : exc_code;
        n_epc = in_delay_slot ? pc - 32'd4 : pc;
      end else if (eret) begin
        n_sr[1] = 1'b0;
      end else if (cp0_we) begin
        if (cp0_addr == 5'd12) n_sr = cp0_wdata & 32'h0000_FC03;
        else if (cp0_addr == 5'd14) n_epc = cp0_wdata;
      end
    end
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); idle(); #1;
    n_vec++; if (take_exc !== 1'b0) begin n_err++; $display("FAIL rst_take: got %b want 0", take_exc); end
    n_vec++; if (exl !== 1'b0) begin n_err++; $display("FAIL rst_exl: got %b want 0", exl); end
    n_vec++; if (epc_out !== 32'd0) begin n_err++; $display("FAIL rst_epc: got %h want 0", epc_out); end
    for (int a = 12; a <= 14; a++) begin
      cp0_addr = 5'(a); #1;
      n_vec++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL rst_reg%0d: got %h want 0", a, cp0_rdata); end
    end
  endtask

  task automatic test_ri_exception();
    idle(); exc_valid = 1; exc_code = 5'd10; pc = 32'h3008; #1;
    n_vec++; if (take_exc !== 1'b1) begin n_err++; $display("FAIL ri_take: got %b want 1", take_exc); end
    n_vec++; if (handler_pc !== HANDLER) begin n_err++; $display("FAIL handler_pc: got %h want %h", handler_pc, HANDLER); end
    tick(); idle(); cp0_addr = 5'd13; #1;
    n_vec++; if (epc_out !== 32'h3008) begin n_err++; $display("FAIL ri_epc: got %h want 3008", epc_out); end
    n_vec++; if (cp0_rdata !== 32'h0000_0028) begin n_err++; $display("FAIL ri_cause: got %h want 00000028", cp0_rdata); end
    n_vec++; if (exl !== 1'b1) begin n_err++; $display("FAIL ri_exl: got %b want 1", exl); end
    eret = 1; tick(); idle(); #1;
    n_vec++; if (exl !== 1'b0) begin n_err++; $display("FAIL ri_eret_exl: got %b want 0", exl); end
  endtask

  task automatic test_delay_slot();
    idle(); exc_valid = 1; exc_code = 5'd12; pc = 32'h300C; in_delay_slot = 1; #1;
    n_vec++; if (take_exc !== 1'b1) begin n_err++; $display("FAIL ds_take: got %b want 1", take_exc); end
    tick(); idle(); cp0_addr = 5'd13; #1;
    n_vec++; if (epc_out !== 32'h3008) begin n_err++; $display("FAIL ds_epc: got %h want 3008", epc_out); end
    n_vec++; if (cp0_rdata !== 32'h8000_0030) begin n_err++; $display("FAIL ds_cause: got %h want 80000030", cp0_rdata); end
    eret = 1; tick(); idle();
    exc_valid = 1; exc_code = 5'd5; pc = 32'h2; in_delay_slot = 1; tick(); idle(); #1;
    n_vec++; if (epc_out !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL ds_wrap_epc: got %h want fffffffe", epc_out); end
    eret = 1; tick(); idle();
  endtask

  task automatic test_interrupt();
    idle(); cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; tick(); idle();
    hw_int = 6'b000001; pc = 32'h3010; #1;
    n_vec++; if (take_exc !== 1'b1) begin n_err++; $display("FAIL int_take: got %b want 1", take_exc); end
    tick(); cp0_addr = 5'd13; #1;
    n_vec++; if (cp0_rdata !== 32'h0000_0400) begin n_err++; $display("FAIL int_cause: got %h want 00000400", cp0_rdata); end
    n_vec++; if (epc_out !== 32'h3010) begin n_err++; $display("FAIL int_epc: got %h want 3010", epc_out); end
    idle(); eret = 1; tick(); idle();
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001; tick(); idle();
    hw_int = 6'b000001; #1;
    n_vec++; if (take_exc !== 1'b0) begin n_err++; $display("FAIL int_masked: got %b want 0", take_exc); end
    tick(); idle();
  endtask

  task automatic test_simultaneous();
    idle(); cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; tick(); idle();
    hw_int = 6'b000001; exc_valid = 1; exc_code = 5'd4; pc = 32'h3020; #1;
    n_vec++; if (take_exc !== 1'b1) begin n_err++; $display("FAIL sim_take: got %b want 1", take_exc); end
    tick(); idle(); exc_valid = 1; exc_code = 5'd5; pc = 32'h5000; cp0_addr = 5'd13; #1;
    n_vec++; if (cp0_rdata[6:2] !== 5'd0) begin n_err++; $display("FAIL sim_code: got %0d want 0", cp0_rdata[6:2]); end
    n_vec++; if (take_exc !== 1'b0) begin n_err++; $display("FAIL nest_take: got %b want 0", take_exc); end
    tick(); idle(); #1;
    n_vec++; if (epc_out !== 32'h3020) begin n_err++; $display("FAIL nest_epc: got %h want 3020", epc_out); end
  endtask

  task automatic test_eret_mtc0();
    idle(); eret = 1; tick(); idle(); #1;
    n_vec++; if (exl !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b want 0", exl); end
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h4000; exc_valid = 1; exc_code = 5'd8; pc = 32'h3040; #1;
    n_vec++; if (take_exc !== 1'b1) begin n_err++; $display("FAIL mtc0take_take: got %b want 1", take_exc); end
    tick(); idle(); #1;
    n_vec++; if (epc_out !== 32'h3040) begin n_err++; $display("FAIL mtc0take_epc: got %h want 3040", epc_out); end
    eret = 1; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403; tick(); idle(); cp0_addr = 5'd12; #1;
    n_vec++; if (exl !== 1'b0) begin n_err++; $display("FAIL eret_wins_exl: got %b want 0", exl); end
    n_vec++; if (cp0_rdata !== 32'h0000_0401) begin n_err++; $display("FAIL eret_wins_sr: got %h want 00000401", cp0_rdata); end
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678; tick(); idle(); #1;
    n_vec++; if (epc_out !== 32'h1234_5678) begin n_err++; $display("FAIL mtc0_epc: got %h want 12345678", epc_out); end
    cp0_we = 1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF; tick(); idle(); cp0_addr = 5'd13; #1;
    n_vec++; if (cp0_rdata !== 32'h0000_0020) begin n_err++; $display("FAIL mtc0_cause_ro: got %h want 00000020", cp0_rdata); end
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF; tick(); idle(); cp0_addr = 5'd12; #1;
    n_vec++; if (cp0_rdata !== 32'h0000_FC03) begin n_err++; $display("FAIL mtc0_sr_mask: got %h want 0000fc03", cp0_rdata); end
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0; tick(); idle();
  endtask

  task automatic test_mfc0();
    idle(); cp0_addr = 5'd15; #1;
    n_vec++; if (cp0_rdata !== PRID) begin n_err++; $display("FAIL mfc0_prid: got %h want %h", cp0_rdata, PRID); end
    cp0_addr = 5'd7; #1;
    n_vec++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL mfc0_r7: got %h want 0", cp0_rdata); end
  endtask

  task automatic test_reset_mid_handler();
    idle(); exc_valid = 1; exc_code = 5'd10; pc = 32'h3050; tick(); idle(); #1;
    n_vec++; if (exl !== 1'b1) begin n_err++; $display("FAIL midrst_pre_exl: got %b want 1", exl); end
    reset = 1; exc_valid = 1; hw_int = 6'h3F; pc = 32'h3060; #1;
    n_vec++; if (take_exc !== 1'b0) begin n_err++; $display("FAIL midrst_take: got %b want 0", take_exc); end
    tick(); idle(); #1;
    n_vec++; if (exl !== 1'b0) begin n_err++; $display("FAIL midrst_exl: got %b want 0", exl); end
    for (int a = 12; a <= 14; a++) begin
      cp0_addr = 5'(a); #1;
      n_vec++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL midrst_reg%0d: got %h want 0", a, cp0_rdata); end
    end
  endtask

  task automatic test_random();
    logic [4:0] addrs [0:5];
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14;
    addrs[3] = 5'd15; addrs[4] = 5'd12; addrs[5] = 5'd0;
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      exc_valid     = ($urandom_range(0, 3) == 0);
      exc_code      = 5'($urandom);
      hw_int        = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      eret          = ($urandom_range(0, 5) == 0);
      cp0_we        = ($urandom_range(0, 3) == 0);
      cp0_addr      = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 5)];
      cp0_wdata     = $urandom;
      pc            = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      in_delay_slot = 1'($urandom);
      #1;
      n_vec++; if (take_exc !== model_take()) begin n_err++; $display("FAIL rnd_take[%0d]: got %b want %b", i, take_exc, model_take()); end
      n_vec++; if (cp0_rdata !== model_read(cp0_addr)) begin n_err++; $display("FAIL rnd_rdata[%0d] reg%0d: got %h want %h", i, cp0_addr, cp0_rdata, model_read(cp0_addr)); end
      n_vec++; if (epc_out !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc_out, m_epc); end
      n_vec++; if (exl !== m_sr[1]) begin n_err++; $display("FAIL rnd_exl[%0d]: got %b want %b", i, exl, m_sr[1]); end
      tick();
    end
    idle();
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_ri_exception();
    test_delay_slot();
    test_interrupt();
    test_simultaneous();
    test_eret_mtc0();
    test_mfc0();
    test_reset_mid_handler();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
